// File: rtl/gate_response_checker.sv
// ---------------------------------------------------------------------------
// gate_response_checker
//
// Self-check engine for a single-output combinational gate-under-test (GUT).
// On each accepted start it walks the GUT input vector stim through
// 0 .. 2**N_IN-1. Each vector is held for SETTLE+1 cycles. At the last edge of
// that hold window the GUT response is compared against TRUTH[stim].
// Mismatches are counted (saturating), and the first failing vector is
// captured.
//
// Parameters
//   N_IN    number of GUT inputs; 2**N_IN vectors per run
//   TRUTH   expected response table, bit i = expected resp for stim == i
//   SETTLE  extra cycles each vector is held before sampling (>= 0)
//   ERR_W   width of the mismatch counter
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      begin a run; only looked at while IDLE
//   resp      in   1      GUT output, sampled unregistered at compare edges
//   stim      out  N_IN   GUT input vector (registered)
//   busy      out  1      run in progress
//   done      out  1      one-cycle pulse after the final compare edge
//   pass      out  1      last run had zero mismatches (valid from done)
//   err_cnt   out  ERR_W  mismatches in last/current run, saturating
//   fail_vld  out  1      at least one mismatch recorded this run
//   fail_vec  out  N_IN   first failing vector of this run
//   state_dbg out  1      current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: start is a level sampled on every rising edge while the FSM is
// IDLE; a high level there launches a run. There is no back-pressure: start
// seen while busy is dropped. done is a single-cycle pulse with no ready
// partner. Because the FSM is already IDLE during the done cycle, a start seen
// in that cycle launches the next run immediately.
// ---------------------------------------------------------------------------
module gate_response_checker #(
  parameter int                      N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]    TRUTH  = 4'b1110,
  parameter int                      SETTLE = 2,
  parameter int                      ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             resp,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_vld,
  output logic [N_IN-1:0]  fail_vec,
  output logic [0:0]       state_dbg
);

  // The hold counter must be able to hold SETTLE. Keep at least one bit so
  // that SETTLE = 0 still produces a legal vector.
  localparam int                HOLD_W   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [HOLD_W-1:0] SETTLE_V = HOLD_W'(SETTLE);
  localparam logic [N_IN-1:0]   LAST_VEC = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state, state_n;
  logic [N_IN-1:0]   stim_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic              done_n;
  logic              pass_n;
  logic [ERR_W-1:0]  err_cnt_n;
  logic              fail_vld_n;
  logic [N_IN-1:0]   fail_vec_n;
  logic              sample;
  logic              mismatch;

  // A compare happens on the edge where the hold counter has already run
  // down to zero, so each vector lives for exactly SETTLE+1 cycles.
  assign sample   = (state == RUN) && (hold == '0);
  assign mismatch = (resp != TRUTH[stim]);

  // ---------------------------------------------------------------------
  // State / datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      stim     <= '0;
      hold     <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vld <= 1'b0;
      fail_vec <= '0;
    end else begin
      state    <= state_n;
      stim     <= stim_n;
      hold     <= hold_n;
      done     <= done_n;
      pass     <= pass_n;
      err_cnt  <= err_cnt_n;
      fail_vld <= fail_vld_n;
      fail_vec <= fail_vec_n;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    // Hold everything by default. done is a pulse, so it defaults low.
    state_n    = state;
    stim_n     = stim;
    hold_n     = hold;
    done_n     = 1'b0;
    pass_n     = pass;
    err_cnt_n  = err_cnt;
    fail_vld_n = fail_vld;
    fail_vec_n = fail_vec;

    unique case (state)
      IDLE: begin
        // Results from the previous run stay visible until a new run is
        // accepted. Accepting a run clears them.
        if (start) begin
          state_n    = RUN;
          stim_n     = '0;
          hold_n     = SETTLE_V;
          pass_n     = 1'b0;
          err_cnt_n  = '0;
          fail_vld_n = 1'b0;
          fail_vec_n = '0;
        end
      end

      RUN: begin
        if (!sample) begin
          hold_n = hold - HOLD_W'(1);
        end else begin
          if (mismatch) begin
            if (err_cnt != ERR_MAX) begin
              err_cnt_n = err_cnt + ERR_W'(1);
            end
            // Only the first failing vector of a run is captured.
            if (!fail_vld) begin
              fail_vld_n = 1'b1;
              fail_vec_n = stim;
            end
          end

          if (stim == LAST_VEC) begin
            // pass must include the compare made on this very edge, so it
            // uses the live mismatch rather than only the registered flag.
            state_n = IDLE;
            stim_n  = '0;
            hold_n  = '0;
            done_n  = 1'b1;
            pass_n  = !(fail_vld || mismatch);
          end else begin
            stim_n = stim + N_IN'(1);
            hold_n = SETTLE_V;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy      = (state == RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_gate_response_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_response_checker
//
// Directed bench for gate_response_checker. u_dut uses the default OR table
// with SETTLE = 2, and a small GUT model selected by resp_mode drives it.
// u_dut1 uses ERR_W = 1 and SETTLE = 0, and its resp is tied low.
// Expected values are computed by hand from the OR truth table.
// ---------------------------------------------------------------------------
module tb_gate_response_checker;

  localparam int N_IN = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0: default parameters ----------------
  logic            start;
  logic            resp;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [7:0]      err_cnt;
  logic            fail_vld;
  logic [N_IN-1:0] fail_vec;
  logic [0:0]      state_dbg;

  // GUT model: 0 = correct OR, 1 = output stuck at 0, 2 = AND gate
  int resp_mode;
  assign resp = (resp_mode == 0) ? (|stim) :
                (resp_mode == 2) ? (&stim) : 1'b0;

  gate_response_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .resp      (resp),
    .stim      (stim),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_vld  (fail_vld),
    .fail_vec  (fail_vec),
    .state_dbg (state_dbg)
  );

  // ---------------- DUT 1: ERR_W=1, SETTLE=0, resp tied low ----------------
  logic            start1;
  logic            resp1;
  logic [N_IN-1:0] stim1;
  logic            busy1;
  logic            done1;
  logic            pass1;
  logic [0:0]      err_cnt1;
  logic            fail_vld1;
  logic [N_IN-1:0] fail_vec1;
  logic [0:0]      state_dbg1;

  assign resp1 = 1'b0;

  gate_response_checker #(
    .N_IN   (2),
    .TRUTH  (4'b1110),
    .SETTLE (0),
    .ERR_W  (1)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .resp      (resp1),
    .stim      (stim1),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .err_cnt   (err_cnt1),
    .fail_vld  (fail_vld1),
    .fail_vec  (fail_vec1),
    .state_dbg (state_dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [N_IN-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock. Inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a run on u_dut and follow it through to done. At the start of the
  // task the DUT must be idle. That includes the done cycle of a previous
  // run. start is pulsed again ahead of edges 4 and 8 of the run, and those
  // pulses must be ignored.
  task automatic do_run(input string tag, input int e_err, input bit e_vld,
                        input int e_vec, input bit e_pass);
    start = 1'b1;
    tick();                     // edge k: run accepted
    start = 1'b0;
    check_eq({tag, " busy@start"}, busy, 1);
    check_eq({tag, " state@start"}, state_dbg, 1);
    check_eq({tag, " stim@start"}, stim, 0);
    check_eq({tag, " err cleared"}, err_cnt, 0);
    check_eq({tag, " done low"}, done, 0);

    // Each vector is held for 3 cycles (SETTLE = 2).
    exp_q.delete();
    for (int j = 1; j < 12; j++) exp_q.push_back(N_IN'(j / 3));

    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j < 12) begin
        check_eq({tag, " stim seq"}, stim, exp_q.pop_front());
        check_eq({tag, " no early done"}, done, 0);
      end else begin
        check_eq({tag, " done@12"}, done, 1);
        check_eq({tag, " busy@done"}, busy, 0);
        check_eq({tag, " stim@done"}, stim, 0);
        check_eq({tag, " err_cnt"}, err_cnt, e_err);
        check_eq({tag, " fail_vld"}, fail_vld, e_vld);
        check_eq({tag, " fail_vec"}, fail_vec, e_vec);
        check_eq({tag, " pass"}, pass, e_pass);
      end
      start = (j == 3 || j == 7) ? 1'b1 : 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    start1    = 1'b0;
    resp_mode = 0;
    repeat (2) tick();

    // Reset state
    check_eq("rst stim", stim, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst pass", pass, 0);
    check_eq("rst err_cnt", err_cnt, 0);
    check_eq("rst fail_vld", fail_vld, 0);
    check_eq("rst fail_vec", fail_vec, 0);
    check_eq("rst state", state_dbg, 0);

    rst_n = 1'b1;
    tick();

    // 1: correct OR gate. The run is clean.
    resp_mode = 0;
    do_run("or", 0, 0, 0, 1);
    tick();
    check_eq("or done pulse 1 cycle", done, 0);
    check_eq("or pass held", pass, 1);

    // 2: output stuck at 0. Vectors 1, 2 and 3 fail.
    resp_mode = 1;
    do_run("tie0", 3, 1, 1, 0);
    tick();
    check_eq("tie0 err held idle", err_cnt, 3);

    // 3: AND gate. Vectors 1 and 2 fail.
    resp_mode = 2;
    do_run("and", 2, 1, 1, 0);
    tick();

    // 4: asynchronous reset while vector 2 is driven
    resp_mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();          // vector 1 sampled at edge k+6, failed
    check_eq("mid stim=2", stim, 2);
    check_eq("mid err=1", err_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async rst busy", busy, 0);
    check_eq("async rst stim", stim, 0);
    check_eq("async rst err", err_cnt, 0);
    check_eq("async rst fail_vld", fail_vld, 0);
    check_eq("async rst state", state_dbg, 0);
    tick();
    rst_n = 1'b1;
    tick();
    resp_mode = 0;
    do_run("post_rst", 0, 0, 0, 1);
    tick();

    // 5: start in the done cycle restarts the run and clears the count
    resp_mode = 1;
    do_run("r1", 3, 1, 1, 0);
    resp_mode = 2;
    do_run("r2", 2, 1, 1, 0);
    tick();

    // 6: ERR_W = 1, SETTLE = 0, resp tied 0 -> done 4 cycles after start
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_eq("d1 busy", busy1, 1);
    for (int j = 1; j <= 4; j++) begin
      tick();
      check_eq("d1 done timing", done1, (j == 4) ? 1 : 0);
      if (j == 1) check_eq("d1 vec0 ok", err_cnt1, 0);
      if (j == 2) check_eq("d1 first err", err_cnt1, 1);
    end
    check_eq("d1 err saturated", err_cnt1, 1);
    check_eq("d1 pass", pass1, 0);
    check_eq("d1 fail_vld", fail_vld1, 1);
    check_eq("d1 fail_vec", fail_vec1, 1);
    check_eq("d1 busy end", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
